// File: rtl/ppl_frame_sched_if.sv
// Frame scheduler signal bundle: frame request, pose in/out, scanner and ray accounting.
// Latency: none, this is wiring only.
// Backpressure: scanner_en gates pixel admission; there is no per-beat valid/ready.
interface ppl_frame_sched_if;
    logic               frame_req;
    logic        [15:0] p_pos_x;
    logic        [15:0] p_pos_y;
    logic        [15:0] p_pos_z;
    logic signed [15:0] p_angle_x;
    logic signed [15:0] p_angle_y;
    logic        [15:0] pos_x_lat;
    logic        [15:0] pos_y_lat;
    logic        [15:0] pos_z_lat;
    logic signed [15:0] angle_x_lat;
    logic signed [15:0] angle_y_lat;
    logic               scanner_en;
    logic               pixel_issue;
    logic               pixel_done;
    logic               busy;
    logic               frame_done;
    logic        [15:0] frame_cnt;
    logic               frame_skip;
    logic               err;

    // Driver side: display/vsync logic plus the pipeline entry and exit.
    modport master (
        output frame_req, p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y,
        output pixel_issue, pixel_done,
        input  pos_x_lat, pos_y_lat, pos_z_lat, angle_x_lat, angle_y_lat,
        input  scanner_en, busy, frame_done, frame_cnt, frame_skip, err
    );

    // Scheduler side.
    modport slave (
        input  frame_req, p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y,
        input  pixel_issue, pixel_done,
        output pos_x_lat, pos_y_lat, pos_z_lat, angle_x_lat, angle_y_lat,
        output scanner_en, busy, frame_done, frame_cnt, frame_skip, err
    );
endinterface

// File: rtl/ppl_frame_sched.sv
// Frame scheduler: latches the pose once per frame, enables the scanner, drains the pipeline.
// Latency: frame_req -> scanner_en 2 cycles; drained pipeline -> frame_done pulse 1 cycle later.
// Backpressure: scanner_en drops after the last pixel of a frame; one extra request is queued, further ones skipped.
module ppl_frame_sched #(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int OUT_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    ppl_frame_sched_if.slave bus
);
    localparam logic [19:0]      TOTAL   = 20'(H_DISP * V_DISP);
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic        [19:0] issue_cnt_q, issue_cnt_d;
    logic   [OUT_W-1:0] outst_q, outst_d;
    logic               pending_q, pending_d;
    logic        [15:0] pos_x_q, pos_x_d;
    logic        [15:0] pos_y_q, pos_y_d;
    logic        [15:0] pos_z_q, pos_z_d;
    logic signed [15:0] ang_x_q, ang_x_d;
    logic signed [15:0] ang_y_q, ang_y_d;
    logic        [15:0] frame_cnt_q, frame_cnt_d;
    logic               scanner_en_q, scanner_en_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_skip_q, frame_skip_d;
    logic               err_q, err_d;

    // Next-state, frame bookkeeping and in-flight ray accounting.
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        outst_d      = outst_q;
        pending_d    = pending_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        pos_z_d      = pos_z_q;
        ang_x_d      = ang_x_q;
        ang_y_d      = ang_y_q;
        frame_cnt_d  = frame_cnt_q;
        frame_skip_d = 1'b0;
        err_d        = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.frame_req || pending_q) begin
                    state_d   = S_LATCH;
                    pending_d = 1'b0;
                end
            end
            S_LATCH: begin
                pos_x_d     = bus.p_pos_x;
                pos_y_d     = bus.p_pos_y;
                pos_z_d     = bus.p_pos_z;
                ang_x_d     = bus.p_angle_x;
                ang_y_d     = bus.p_angle_y;
                issue_cnt_d = '0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (bus.pixel_issue) begin
                    issue_cnt_d = issue_cnt_q + 20'd1;
                    if (issue_cnt_q + 20'd1 >= TOTAL) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // frame_cnt moves together with the frame_done pulse.
                if (outst_q == '0) begin
                    state_d     = S_DONE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                // A queued request goes first; a request arriving now takes its place in the queue.
                if (pending_q) begin
                    state_d   = S_LATCH;
                    pending_d = bus.frame_req;
                end else if (bus.frame_req) begin
                    state_d = S_LATCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Requests arriving while a frame is in progress: queue one, drop the rest.
        if (bus.frame_req && (state_q == S_LATCH || state_q == S_RUN || state_q == S_DRAIN)) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else begin
                frame_skip_d = 1'b1;
            end
        end

        // An issue is only legal while the scanner is enabled.
        if (bus.pixel_issue && state_q != S_RUN) begin
            err_d = 1'b1;
        end

        // Outstanding rays; a simultaneous issue and done cancel out.
        unique case ({bus.pixel_issue, bus.pixel_done})
            2'b10: begin
                if (outst_q == OUT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    outst_d = outst_q + 1'b1;
                end
            end
            2'b01: begin
                if (outst_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    outst_d = outst_q - 1'b1;
                end
            end
            default: ;
        endcase

        scanner_en_d = (state_d == S_RUN);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            issue_cnt_q  <= '0;
            outst_q      <= '0;
            pending_q    <= 1'b0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            pos_z_q      <= '0;
            ang_x_q      <= '0;
            ang_y_q      <= '0;
            frame_cnt_q  <= '0;
            scanner_en_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_skip_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            outst_q      <= outst_d;
            pending_q    <= pending_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            pos_z_q      <= pos_z_d;
            ang_x_q      <= ang_x_d;
            ang_y_q      <= ang_y_d;
            frame_cnt_q  <= frame_cnt_d;
            scanner_en_q <= scanner_en_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_skip_q <= frame_skip_d;
            err_q        <= err_d;
        end
    end

    assign bus.pos_x_lat   = pos_x_q;
    assign bus.pos_y_lat   = pos_y_q;
    assign bus.pos_z_lat   = pos_z_q;
    assign bus.angle_x_lat = ang_x_q;
    assign bus.angle_y_lat = ang_y_q;
    assign bus.scanner_en  = scanner_en_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.frame_skip  = frame_skip_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ppl_frame_sched.sv
// Bench for the frame scheduler with a tiny 4x2 frame and a 4-bit outstanding counter.
// Latency: checks the 2-cycle request-to-scanner path and frame_done timing via a scoreboard.
// Backpressure: exercises request queuing, skipping, drain hold-off and reset mid-frame.
module tb_ppl_frame_sched;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ppl_frame_sched_if ifc ();

    ppl_frame_sched #(.H_DISP(H), .V_DISP(V), .OUT_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct {
        logic [15:0] cnt;
        logic [15:0] pos_x;
    } exp_t;

    typedef struct {
        logic       iss;
        logic       dn;
        logic [3:0] outst;
        logic       scan;
    } vec_t;

    int          checks    = 0;
    int          failures  = 0;
    int          done_seen = 0;
    logic [15:0] model_cnt = 16'd0;
    exp_t        sb[$];
    vec_t        tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [15:0] px);
        exp_t e;
        model_cnt = model_cnt + 16'd1;
        e.cnt     = model_cnt;
        e.pos_x   = px;
        sb.push_back(e);
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.pixel_issue = 1'b1;
            tick();
        end
        ifc.pixel_issue = 1'b0;
    endtask

    task automatic done_n(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.pixel_done = 1'b1;
            tick();
        end
        ifc.pixel_done = 1'b0;
    endtask

    task automatic pulse_req();
        ifc.frame_req = 1'b1;
        tick();
        ifc.frame_req = 1'b0;
    endtask

    task automatic wait_scan(input string name);
        int n = 0;
        while (!ifc.scanner_en && n < 20) begin
            tick();
            n++;
        end
        chk(name, ifc.scanner_en, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (ifc.busy && n < 40) begin
            tick();
            n++;
        end
        chk(name, ifc.busy, 0);
    endtask

    // Scoreboard: each frame_done must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && ifc.frame_done) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done: got frame_cnt 0x%0h expected no pulse", ifc.frame_cnt);
            end else begin
                e = sb.pop_front();
                chk("sb_frame_cnt", ifc.frame_cnt, e.cnt);
                chk("sb_pos_x_lat", ifc.pos_x_lat, e.pos_x);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int seen0;

        // Simultaneous issue/done rows sit at 3 and 6; scanner drops on row 8 (8th issue).
        tbl[0]  = '{1'b1, 1'b0, 4'd1, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 4'd2, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 4'd3, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 4'd3, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 4'd2, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 4'd3, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 4'd3, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 4'd4, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 4'd5, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'd4, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'd3, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'd2, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 4'd1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 4'd0, 1'b0};

        rst             = 1'b1;
        ifc.frame_req   = 1'b0;
        ifc.pixel_issue = 1'b0;
        ifc.pixel_done  = 1'b0;
        ifc.p_pos_x     = 16'h0100;
        ifc.p_pos_y     = 16'h0111;
        ifc.p_pos_z     = 16'h0122;
        ifc.p_angle_x   = 16'sd45;
        ifc.p_angle_y   = -16'sd300;
        tick();
        tick();

        // Reset values.
        chk("rst_scanner_en", ifc.scanner_en, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_frame_done", ifc.frame_done, 0);
        chk("rst_frame_skip", ifc.frame_skip, 0);
        chk("rst_err", ifc.err, 0);
        chk("rst_frame_cnt", ifc.frame_cnt, 0);
        chk("rst_pos_x_lat", ifc.pos_x_lat, 0);
        chk("rst_outst", dut.outst_q, 0);
        rst = 1'b0;
        tick();

        // Single frame, each done 3 cycles after its issue; pose changes during RUN.
        expect_frame(16'h0100);
        pulse_req();
        chk("latch_scanner_low", ifc.scanner_en, 0);
        chk("latch_busy", ifc.busy, 1);
        tick();
        chk("scan_2cyc", ifc.scanner_en, 1);
        chk("pos_x_lat", ifc.pos_x_lat, 16'h0100);
        chk("pos_z_lat", ifc.pos_z_lat, 16'h0122);
        chk("angle_y_lat", {16'h0, ifc.angle_y_lat}, 32'h0000FED4);
        ifc.p_pos_x = 16'h0200;
        for (int c = 0; c < 11; c++) begin
            ifc.pixel_issue = (c < 8);
            ifc.pixel_done  = (c >= 3);
            tick();
            if (c == 6) chk("scan_before_last", ifc.scanner_en, 1);
            if (c == 7) chk("scan_drop", ifc.scanner_en, 0);
        end
        ifc.pixel_issue = 1'b0;
        ifc.pixel_done  = 1'b0;
        wait_idle("frame1_idle");
        chk("pose_hold", ifc.pos_x_lat, 16'h0100);
        chk("frame1_cnt", ifc.frame_cnt, 1);
        chk("frame1_err", ifc.err, 0);

        // Table-driven frame: outstanding accounting including simultaneous issue/done.
        expect_frame(16'h0200);
        pulse_req();
        wait_scan("tbl_scan");
        for (int i = 0; i < 14; i++) begin
            ifc.pixel_issue = tbl[i].iss;
            ifc.pixel_done  = tbl[i].dn;
            tick();
            ifc.pixel_issue = 1'b0;
            ifc.pixel_done  = 1'b0;
            chk($sformatf("tbl%0d_outst", i), dut.outst_q, tbl[i].outst);
            chk($sformatf("tbl%0d_scan", i), ifc.scanner_en, tbl[i].scan);
            chk($sformatf("tbl%0d_err", i), ifc.err, 0);
        end
        wait_idle("tbl_idle");
        chk("tbl_pos_x_lat", ifc.pos_x_lat, 16'h0200);

        // Request queuing: one queued in RUN, one skipped in DRAIN, DONE goes straight to LATCH.
        seen0 = done_seen;
        ifc.p_pos_x = 16'h0300;
        expect_frame(16'h0300);
        pulse_req();
        wait_scan("q_scan");
        expect_frame(16'h0300);
        pulse_req();
        chk("q_no_skip", ifc.frame_skip, 0);
        issue_n(8);
        chk("q_drain_scan", ifc.scanner_en, 0);
        pulse_req();
        chk("q_skip_pulse", ifc.frame_skip, 1);
        tick();
        chk("q_skip_end", ifc.frame_skip, 0);
        done_n(8);
        n = 0;
        while (!ifc.frame_done && n < 10) begin
            tick();
            n++;
        end
        chk("q_done_seen", ifc.frame_done, 1);
        tick();
        chk("q_latch_busy", ifc.busy, 1);
        chk("q_latch_scan", ifc.scanner_en, 0);
        tick();
        chk("q_run_scan", ifc.scanner_en, 1);
        issue_n(8);
        done_n(8);
        wait_idle("q_idle");
        chk("q_two_done", done_seen - seen0, 2);

        // Spurious done in IDLE.
        chk("spur_err_before", ifc.err, 0);
        ifc.pixel_done = 1'b1;
        tick();
        ifc.pixel_done = 1'b0;
        chk("spur_err", ifc.err, 1);
        chk("spur_outst", dut.outst_q, 0);

        // Reset in DRAIN with 5 rays outstanding.
        expect_frame(16'h0300);
        pulse_req();
        wait_scan("rd_scan");
        issue_n(8);
        done_n(3);
        chk("rd_outst", dut.outst_q, 5);
        seen0 = done_seen;
        rst = 1'b1;
        #1;
        chk("rd_busy", ifc.busy, 0);
        chk("rd_scan", ifc.scanner_en, 0);
        chk("rd_err", ifc.err, 0);
        chk("rd_frame_cnt", ifc.frame_cnt, 0);
        chk("rd_pos_x_lat", ifc.pos_x_lat, 0);
        chk("rd_outst0", dut.outst_q, 0);
        sb.delete();
        model_cnt = 16'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rd_no_done", done_seen - seen0, 0);
        chk("rd_cnt_after", ifc.frame_cnt, 0);

        // frame_cnt wrap from 0xFFFF.
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        tick();
        release dut.frame_cnt_q;
        tick();
        chk("wrap_preload", ifc.frame_cnt, 16'hFFFF);
        model_cnt = 16'hFFFF;
        expect_frame(16'h0300);
        pulse_req();
        wait_scan("wrap_scan");
        issue_n(8);
        done_n(8);
        wait_idle("wrap_idle");
        chk("wrap_cnt", ifc.frame_cnt, 0);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
